spike_rate_meter: RTL and testbench

- Downstream consumer of the LIF neuron spike output; it measures firing rate.
- Counts rising edges of the `spike` input over a programmable window of clock cycles.
- At each window end it publishes the count plus a saturation flag as a one-cycle-valid sample.
- Drives the display and uio pins in place of raw membrane state.

---
 rtl/snn_pkg.sv | 26 ++
 rtl/spike_edge_det.sv | 20 ++
 rtl/spike_rate_meter.sv | 154 +++++++++++++++
 tb/tb_spike_rate_meter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN widths, rate meter state type and saturating helpers.
package snn_pkg;

  localparam int SNN_CNT_W = 8;
  localparam int SNN_WIN_W = 16;

  typedef enum logic {
    IDLE,
    RUN
  } rate_state_t;

  // Adds inc to v, clipping at 2^w-1; callers cast the result to width w.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        inc,
    input int unsigned w
  );
    logic [31:0] mx;
    mx = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    if (inc && (v >= mx))
      sat_inc = mx;
    else
      sat_inc = v + {31'd0, inc};
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Registers a spike level and emits a one-cycle pulse on its rising edge.
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic spike,
  output logic rise
);

  logic spike_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      spike_q <= 1'b0;
    else
      spike_q <= spike;
  end

  assign rise = spike & ~spike_q;

endmodule

// File: rtl/spike_rate_meter.sv
// Windowed spike-rate meter; SPIKE_RATE_ISI_EN adds inter-spike interval outputs.
module spike_rate_meter
  import snn_pkg::*;
#(
  parameter int CNT_W = SNN_CNT_W,
  parameter int WIN_W = SNN_WIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike,
  input  logic             en,
  input  logic             clear,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic             busy
`ifdef SPIKE_RATE_ISI_EN
  ,
  output logic [WIN_W-1:0] isi,
  output logic             isi_valid
`endif
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  rate_state_t      state;
  logic             rise;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] wl_eff;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic             sat_acc;
  logic             ovf;
  logic             win_end;

  spike_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (spike),
    .rise  (rise)
  );

  always_comb begin
    wl_eff  = (window_len == '0) ? WIN_W'(1) : window_len;
    ovf     = rise && (acc == ACC_MAX);
    acc_nxt = CNT_W'(sat_inc(32'(acc), rise, CNT_W));
    win_end = (state == RUN) && (win_cnt == (win_len_q - WIN_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      win_cnt    <= '0;
      win_len_q  <= '0;
      acc        <= '0;
      sat_acc    <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      busy       <= 1'b0;
      win_cnt    <= '0;
      win_len_q  <= '0;
      acc        <= '0;
      sat_acc    <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          acc     <= '0;
          sat_acc <= 1'b0;
          win_cnt <= '0;
          if (en) begin
            state     <= RUN;
            busy      <= 1'b1;
            win_len_q <= wl_eff;
          end
        end
        RUN: begin
          if (win_end) begin
            rate       <= acc_nxt;
            rate_sat   <= sat_acc | ovf;
            rate_valid <= 1'b1;
            acc        <= '0;
            sat_acc    <= 1'b0;
            win_cnt    <= '0;
            win_len_q  <= wl_eff;
          end else begin
            acc     <= acc_nxt;
            sat_acc <= sat_acc | ovf;
            win_cnt <= win_cnt + WIN_W'(1);
          end
          // A completed window still publishes above; a partial one is dropped.
          if (!en) begin
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            sat_acc <= 1'b0;
            win_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef SPIKE_RATE_ISI_EN
  logic [WIN_W-1:0] isi_cnt;
  logic             isi_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt   <= '0;
      isi_seen  <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else if (clear) begin
      isi_cnt   <= '0;
      isi_seen  <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (state != RUN) begin
        isi_cnt  <= '0;
        isi_seen <= 1'b0;
      end else begin
        // isi_cnt holds cycles elapsed since the last counted edge.
        if (rise) begin
          isi_cnt  <= WIN_W'(1);
          isi_seen <= 1'b1;
          if (isi_seen) begin
            isi       <= isi_cnt;
            isi_valid <= 1'b1;
          end
        end else begin
          isi_cnt <= WIN_W'(sat_inc(32'(isi_cnt), 1'b1, WIN_W));
        end
        if (!en) begin
          isi_cnt  <= '0;
          isi_seen <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed bench for spike_rate_meter (8-bit and 4-bit count instances).
module tb_spike_rate_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spike = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] window_len = 16'd0;

  logic [7:0]  rate;
  logic        rate_valid;
  logic        rate_sat;
  logic        busy;
  logic [3:0]  rate4;
  logic        rate_valid4;
  logic        rate_sat4;
  logic        busy4;
`ifdef SPIKE_RATE_ISI_EN
  logic [15:0] isi;
  logic        isi_valid;
  logic [15:0] isi4;
  logic        isi_valid4;
`endif

  int errors = 0;
  int checks = 0;

  spike_rate_meter #(.CNT_W(8), .WIN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike      (spike),
    .en         (en),
    .clear      (clear),
    .window_len (window_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .rate_sat   (rate_sat),
    .busy       (busy)
`ifdef SPIKE_RATE_ISI_EN
    ,
    .isi        (isi),
    .isi_valid  (isi_valid)
`endif
  );

  spike_rate_meter #(.CNT_W(4), .WIN_W(16)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike      (spike),
    .en         (en),
    .clear      (clear),
    .window_len (window_len),
    .rate       (rate4),
    .rate_valid (rate_valid4),
    .rate_sat   (rate_sat4),
    .busy       (busy4)
`ifdef SPIKE_RATE_ISI_EN
    ,
    .isi        (isi4),
    .isi_valid  (isi_valid4)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [15:0] len);
    en = 1'b0;
    clear = 1'b1;
    spike = 1'b0;
    window_len = len;
    tick();
    clear = 1'b0;
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    window_len = 16'd3;
    for (int i = 0; i < 20; i++) begin
      spike = 1'($urandom_range(0, 1));
      en = (i > 1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rate, rate_valid, rate_sat, busy} !== 11'd0 ||
        {rate4, rate_valid4, rate_sat4, busy4} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rate=%0d v=%b s=%b b=%b rate4=%0d b4=%b want all 0",
               rate, rate_valid, rate_sat, busy, rate4, busy4);
    end
`ifdef SPIKE_RATE_ISI_EN
    checks++;
    if (isi !== 16'd0 || isi_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_isi: got isi=%0d v=%b want 0 0", isi, isi_valid);
    end
`endif
    en = 1'b0;
    spike = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rate_valid !== 1'b0 || busy !== 1'b0 || rate !== 8'd0) begin
        errors++;
        $display("FAIL reset_release[%0d]: got v=%b b=%b rate=%0d want 0 0 0",
                 i, rate_valid, busy, rate);
      end
    end
    restart(16'd1);
    spike = 1'b1;
    tick();
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd1) begin
      errors++;
      $display("FAIL clear_pre: got v=%b rate=%0d want 1 1", rate_valid, rate);
    end
    en = 1'b0;
    clear = 1'b1;
    tick();
    checks++;
    if ({rate, rate_valid, rate_sat, busy} !== 11'd0) begin
      errors++;
      $display("FAIL clear_outputs: got rate=%0d v=%b s=%b b=%b want all 0",
               rate, rate_valid, rate_sat, busy);
    end
    clear = 1'b0;
    spike = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rate_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clear_release[%0d]: got v=%b b=%b want 0 0", i, rate_valid, busy);
      end
    end
  endtask

  task automatic test_basic_count();
    restart(16'd10);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    for (int w = 0; w < 3; w++) begin
      for (int p = 0; p < 10; p++) begin
        spike = (p == 1 || p == 4 || p == 7);
        tick();
        checks++;
        if (rate_valid !== (p == 9)) begin
          errors++;
          $display("FAIL basic_valid w%0d p%0d: got %b want %b", w, p, rate_valid, p == 9);
        end
        if (p == 9) begin
          checks++;
          if (rate !== 8'd3 || rate_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_rate w%0d: got %0d sat=%b want 3 sat=0", w, rate, rate_sat);
          end
        end
      end
    end
  endtask

  task automatic test_level();
    restart(16'd50);
    for (int p = 0; p < 50; p++) begin
      spike = (p >= 10 && p < 35);
      tick();
    end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd1) begin
      errors++;
      $display("FAIL level_rate: got v=%b rate=%0d want 1 1", rate_valid, rate);
    end
    restart(16'd0);
    for (int p = 0; p < 4; p++) begin
      spike = (p % 2 == 0);
      tick();
      checks++;
      if (rate_valid !== 1'b1 || rate !== 8'((p % 2 == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL win0 p%0d: got v=%b rate=%0d want 1 %0d",
                 p, rate_valid, rate, (p % 2 == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    restart(16'd64);
    for (int p = 0; p < 64; p++) begin
      spike = (p % 2 == 1);
      tick();
    end
    checks++;
    if (rate_valid4 !== 1'b1 || rate4 !== 4'd15 || rate_sat4 !== 1'b1) begin
      errors++;
      $display("FAIL sat4: got v=%b rate=%0d sat=%b want 1 15 1", rate_valid4, rate4, rate_sat4);
    end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd32 || rate_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat8: got v=%b rate=%0d sat=%b want 1 32 0", rate_valid, rate, rate_sat);
    end
    for (int p = 0; p < 64; p++) begin
      spike = 1'b0;
      tick();
    end
    checks++;
    if (rate_valid4 !== 1'b1 || rate4 !== 4'd0 || rate_sat4 !== 1'b0 ||
        rate !== 8'd0 || rate_sat !== 1'b0) begin
      errors++;
      $display("FAIL quiet: got rate4=%0d sat4=%b rate=%0d sat=%b want 0 0 0 0",
               rate4, rate_sat4, rate, rate_sat);
    end
  endtask

  task automatic test_window_change();
    restart(16'd10);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) window_len = 16'd5;
      spike = 1'b0;
      tick();
      checks++;
      if (rate_valid !== (i == 9 || i == 14 || i == 19)) begin
        errors++;
        $display("FAIL wchange i%0d: got %b want %b", i, rate_valid,
                 (i == 9 || i == 14 || i == 19));
      end
    end
  endtask

  task automatic test_abort();
    restart(16'd10);
    for (int p = 0; p < 10; p++) begin
      spike = (p == 1 || p == 4);
      tick();
    end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd2) begin
      errors++;
      $display("FAIL abort_pre: got v=%b rate=%0d want 1 2", rate_valid, rate);
    end
    for (int p = 0; p < 13; p++) begin
      spike = (p == 1);
      if (p == 7) en = 1'b0;
      tick();
      checks++;
      if (rate_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_valid p%0d: got %b want 0", p, rate_valid);
      end
    end
    checks++;
    if (rate !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: got rate=%0d busy=%b want 2 0", rate, busy);
    end
  endtask

  task automatic test_clear_at_end();
    restart(16'd10);
    for (int p = 0; p < 10; p++) begin
      spike = (p == 2);
      tick();
    end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd1) begin
      errors++;
      $display("FAIL clrend_pre: got v=%b rate=%0d want 1 1", rate_valid, rate);
    end
    for (int p = 0; p < 10; p++) begin
      spike = 1'b0;
      clear = (p == 9);
      tick();
    end
    checks++;
    if (rate_valid !== 1'b0 || rate !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clrend: got v=%b rate=%0d busy=%b want 0 0 0", rate_valid, rate, busy);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clrend_rerun: got busy=%b want 1", busy);
    end
  endtask

  task automatic test_en_fall_at_end();
    restart(16'd10);
    for (int p = 0; p < 10; p++) begin
      spike = (p == 5);
      if (p == 9) en = 1'b0;
      tick();
    end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enfall: got v=%b rate=%0d busy=%b want 1 1 0", rate_valid, rate, busy);
    end
    tick();
    checks++;
    if (rate_valid !== 1'b0 || rate !== 8'd1) begin
      errors++;
      $display("FAIL enfall_after: got v=%b rate=%0d want 0 1", rate_valid, rate);
    end
  endtask

`ifdef SPIKE_RATE_ISI_EN
  task automatic test_isi();
    restart(16'd100);
    for (int i = 0; i <= 70010; i++) begin
      spike = (i == 2 || i == 9 || i == 70009);
      tick();
      if (i == 2 || i == 10) begin
        checks++;
        if (isi_valid !== 1'b0) begin
          errors++;
          $display("FAIL isi_quiet i%0d: got v=%b want 0", i, isi_valid);
        end
      end
      if (i == 9) begin
        checks++;
        if (isi_valid !== 1'b1 || isi !== 16'd7) begin
          errors++;
          $display("FAIL isi_7: got v=%b isi=%0d want 1 7", isi_valid, isi);
        end
      end
      if (i == 70009) begin
        checks++;
        if (isi_valid !== 1'b1 || isi !== 16'd65535) begin
          errors++;
          $display("FAIL isi_sat: got v=%b isi=%0d want 1 65535", isi_valid, isi);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_count();
    test_level();
    test_saturation();
    test_window_change();
    test_abort();
    test_clear_at_end();
    test_en_fall_at_end();
`ifdef SPIKE_RATE_ISI_EN
    test_isi();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
